gcd_req_arbiter: RTL and testbench
==================================

// Module: gcd_req_arbiter
// PURPOSE
//   Shares one GCD engine (controller + datapath pair) between NREQ requesters.
//   Round-robin arbitration picks a request and sequences the engine via go/done.
//   The result is returned on a single response channel tagged with the requester id.
//   Sits between the requesting units and the engine instance.
// PARAMETERS
//   NREQ           4     number of requesters (2..8)
//   WIDTH          32    operand/result width
//   TIMEOUT_CYCLES 4096  watchdog limit in engine cycles (used only with GCD_ARB_TIMEOUT_EN)
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous reset, active-high
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        per-requester accept; one-hot or zero
//   req_a      in   NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand b, same packing
//   eng_go     out  1           one-cycle start pulse to engine
//   eng_a      out  WIDTH       operand a to engine; held stable while busy
//   eng_b      out  WIDTH       operand b to engine; held stable while busy
//   eng_done   in   1           engine result valid (a_eq_b reached)
//   eng_gcd    in   WIDTH       engine result
//   rsp_valid  out  1           response valid
//   rsp_ready  in   1           response consumer accept
//   rsp_gcd    out  WIDTH       result
//   rsp_id     out  $clog2(NREQ) id of the requester that owns the result
//   rsp_err    out  1           result invalid (timeout); 0 when the macro is absent
//   busy       out  1           high in every state except IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0. All of req_ready, eng_go, rsp_valid, rsp_err and busy are 0.
//   Reset also clears eng_a, eng_b, rsp_gcd and rsp_id to 0. Reset mid-operation aborts
//   silently and loses the in-flight result.
//   FSM states: IDLE, LAUNCH, WAIT, RESP.
//   IDLE:
//     - If any req_valid is set, grant the first set bit searching from rr_ptr upward
//       (wrapping at NREQ).
//     - Same cycle: req_ready[g]=1 (combinational on state and req_valid); capture
//       operands and g.
//     - Next state: LAUNCH, or RESP if a zero operand is seen (see below).
//     - rr_ptr <= g+1 mod NREQ.
//   Zero bypass (the subtractive engine never terminates on a zero operand):
//     - a==0 gives b; b==0 gives a; both zero gives 0.
//     - Go straight to RESP; eng_go is not asserted.
//   LAUNCH: eng_go=1 for exactly this cycle, then WAIT.
//   WAIT: stay until eng_done=1; capture eng_gcd into rsp_gcd, then RESP.
//     eng_done while not in WAIT is ignored.
//   RESP:
//     - rsp_valid=1; rsp_gcd, rsp_id and rsp_err are held stable until rsp_valid &&
//       rsp_ready.
//     - On that handshake go to IDLE. No new grant in the same cycle; minimum
//       issue-to-issue spacing is 1 idle cycle.
//   Latency: grant -> eng_go = 1 cycle; eng_done -> rsp_valid = 1 cycle;
//     bypass grant -> rsp_valid = 1 cycle.
//   Only one request is outstanding. Requesters keep req_valid until they see req_ready.
//     Dropping req_valid before the grant is legal.
//   Simultaneous requests: only the granted bit is accepted; the others wait.
//     The pointer guarantees each requester is granted within NREQ grants.
// CONFIGURATION
//   GCD_ARB_TIMEOUT_EN defined:
//     - A WIDTH-independent 32-bit counter runs in WAIT.
//     - When it reaches TIMEOUT_CYCLES without eng_done: rsp_err=1, rsp_gcd=0, go to RESP.
//     - Engine recovery is the system's job.
//   Not defined: no counter; WAIT waits forever; rsp_err is tied 0.
// TESTING
//   1. Single req0 a=48 b=18 -> eng_go once; eng_done/eng_gcd=6 -> rsp_valid, rsp_gcd=6,
//      rsp_id=0, rsp_err=0.
//   2. req_valid=4'b1111 held, all operands 12/8 -> grants in order 0,1,2,3,0.
//      Four rsp_gcd=4 with matching rsp_id.
//   3. req2 a=0 b=35 -> no eng_go; rsp_gcd=35 one cycle after grant.
//      Also a=0 b=0 -> rsp_gcd=0.
//   4. rsp_ready=0 for 10 cycles in RESP -> rsp_* stable; no new grant while req1 is pending.
//      Grant 1 cycle after release.
//   5. rst pulsed in WAIT -> next cycle all outputs 0, state IDLE; late eng_done ignored.
//   6. GCD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, eng_done never asserted -> rsp_valid with
//      rsp_err=1, rsp_gcd=0. Without the macro: still in WAIT, busy=1.

Source files
------------

// File: rtl/gcd_req_arbiter.sv
// Round-robin front end that shares one GCD engine among NREQ requesters.
// Optional watchdog on the engine wait is enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_req_arbiter #(
  parameter int NREQ           = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    eng_go,
  output logic [WIDTH-1:0]        eng_a,
  output logic [WIDTH-1:0]        eng_b,
  input  logic                    eng_done,
  input  logic [WIDTH-1:0]        eng_gcd,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_gcd,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDW-1:0]     r_rr_ptr;
  logic [WIDTH-1:0]   r_eng_a;
  logic [WIDTH-1:0]   r_eng_b;
  logic [WIDTH-1:0]   r_rsp_gcd;
  logic [IDW-1:0]     r_rsp_id;

  logic [WIDTH-1:0]   w_op_a [NREQ];
  logic [WIDTH-1:0]   w_op_b [NREQ];
  logic [IDW-1:0]     w_cand [NREQ];
  logic               w_found;
  logic [IDW-1:0]     w_grant;
  logic [IDW-1:0]     w_ptr_next;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_zero;
  logic [WIDTH-1:0]   w_bypass_gcd;
  logic               w_accept;
  logic               w_timeout_hit;

  // w_cand[k] is the requester examined k-th, starting at the round-robin pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_a[gi] = req_a[gi*WIDTH +: WIDTH];
    assign w_op_b[gi] = req_b[gi*WIDTH +: WIDTH];
    assign w_cand[gi] = (int'(r_rr_ptr) + gi >= NREQ) ? IDW'(int'(r_rr_ptr) + gi - NREQ)
                                                      : IDW'(int'(r_rr_ptr) + gi);
  end

  // Scan from farthest to nearest so the candidate closest to the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[w_cand[k]]) begin
        w_found = 1'b1;
        w_grant = w_cand[k];
      end
    end
  end

  assign w_sel_a      = w_op_a[w_grant];
  assign w_sel_b      = w_op_b[w_grant];
  assign w_zero       = (w_sel_a == '0) || (w_sel_b == '0);
  assign w_bypass_gcd = (w_sel_a == '0) ? w_sel_b : w_sel_a;
  assign w_ptr_next   = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
  assign w_accept     = (r_state == IDLE) && w_found && !rst;

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    eng_go       = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready[w_grant] = 1'b1;
          w_state_next       = w_zero ? RESP : LAUNCH;
        end
      end
      LAUNCH: begin
        eng_go       = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (eng_done || w_timeout_hit) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_eng_a   <= '0;
      r_eng_b   <= '0;
      r_rsp_gcd <= '0;
      r_rsp_id  <= '0;
    end else begin
      if (w_accept) begin
        r_eng_a  <= w_sel_a;
        r_eng_b  <= w_sel_b;
        r_rsp_id <= w_grant;
        r_rr_ptr <= w_ptr_next;
        if (w_zero) begin
          r_rsp_gcd <= w_bypass_gcd;
        end
      end
      if (r_state == WAIT) begin
        if (eng_done) begin
          r_rsp_gcd <= eng_gcd;
        end else if (w_timeout_hit) begin
          r_rsp_gcd <= '0;
        end
      end
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_rsp_err;

  // Counts cycles spent in WAIT; fires on the TIMEOUT_CYCLES-th cycle without eng_done.
  assign w_timeout_hit = (r_state == WAIT) && !eng_done &&
                         (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (r_state != WAIT)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == WAIT) begin
      if (eng_done) begin
        r_rsp_err <= 1'b0;
      end else if (w_timeout_hit) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout_hit = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  assign eng_a   = r_eng_a;
  assign eng_b   = r_eng_b;
  assign rsp_gcd = r_rsp_gcd;
  assign rsp_id  = r_rsp_id;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Self-checking bench for gcd_req_arbiter: directed scenarios plus a randomized run
// against an arbitration/GCD reference model and a behavioural engine.
module tb_gcd_req_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int TO    = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  eng_go;
  logic [WIDTH-1:0]      eng_a;
  logic [WIDTH-1:0]      eng_b;
  logic                  eng_done;
  logic [WIDTH-1:0]      eng_gcd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_gcd;
  logic [1:0]            rsp_id;
  logic                  rsp_err;
  logic                  busy;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  int n_checks = 0;
  int n_pass   = 0;
  int rr       = 0;

  // behavioural engine
  bit               eng_auto = 1'b0;
  bit               e_pend   = 1'b0;
  bit               e_fire   = 1'b0;
  int               e_dly    = 0;
  logic [WIDTH-1:0] e_res    = '0;
  int               go_cnt   = 0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[gi*WIDTH +: WIDTH] = op_a[gi];
    assign req_b[gi*WIDTH +: WIDTH] = op_b[gi];
  end

  gcd_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done), .eng_gcd(eng_gcd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int exp_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (e_fire) begin
      eng_done = 1'b0;
      e_fire   = 1'b0;
    end
    if (rst) begin
      e_pend = 1'b0;
    end else if (eng_go === 1'b1) begin
      go_cnt++;
      if (eng_auto) begin
        e_res  = ref_gcd(eng_a, eng_b);
        e_dly  = $urandom_range(0, 4);
        e_pend = 1'b1;
      end
    end else if (e_pend) begin
      if (e_dly == 0) begin
        eng_done = 1'b1;
        eng_gcd  = e_res;
        e_fire   = 1'b1;
        e_pend   = 1'b0;
      end else begin
        e_dly--;
      end
    end
  end

  task automatic handshake;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp;
    int c = 0;
    while (rsp_valid !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = 5; op_b[i] = 5; end
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready_in_rst got=%b exp=0000", req_ready); else n_pass++;
    req_valid = '0;
    rst = 1'b0;
    rr = 0;
    @(negedge clk);
    n_checks++; if ({eng_go, rsp_valid, rsp_err, busy} !== 4'b0000) $display("FAIL reset_ctrl got=%b exp=0000", {eng_go, rsp_valid, rsp_err, busy}); else n_pass++;
    n_checks++; if (eng_a !== 0 || eng_b !== 0) $display("FAIL reset_eng_ops got=%0d/%0d exp=0/0", eng_a, eng_b); else n_pass++;
    n_checks++; if (rsp_gcd !== 0 || rsp_id !== 0) $display("FAIL reset_rsp got=%0d/%0d exp=0/0", rsp_gcd, rsp_id); else n_pass++;
  endtask

  task automatic test_single;
    int g0;
    eng_auto = 1'b0;
    @(negedge clk);
    op_a[0] = 48; op_b[0] = 18; req_valid = 4'b0001;
    #1;
    g0 = go_cnt;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL t1_ready got=%b exp=0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    n_checks++; if (eng_go !== 1'b1 || busy !== 1'b1) $display("FAIL t1_go got go=%b busy=%b exp 1/1", eng_go, busy); else n_pass++;
    n_checks++; if (eng_a !== 48 || eng_b !== 18) $display("FAIL t1_ops got=%0d/%0d exp=48/18", eng_a, eng_b); else n_pass++;
    @(negedge clk);
    n_checks++; if (eng_go !== 1'b0) $display("FAIL t1_go_pulse got=%b exp=0", eng_go); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL t1_early_rsp got=%b exp=0", rsp_valid); else n_pass++;
    eng_done = 1'b1; eng_gcd = 6;
    @(negedge clk);
    eng_done = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== 6) $display("FAIL t1_rsp got v=%b gcd=%0d exp v=1 gcd=6", rsp_valid, rsp_gcd); else n_pass++;
    n_checks++; if (rsp_id !== 0 || rsp_err !== 1'b0) $display("FAIL t1_tag got id=%0d err=%b exp 0/0", rsp_id, rsp_err); else n_pass++;
    #1;
    n_checks++; if (go_cnt - g0 !== 1) $display("FAIL t1_go_count got=%0d exp=1", go_cnt - g0); else n_pass++;
    handshake();
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t1_idle got v=%b busy=%b exp 0/0", rsp_valid, busy); else n_pass++;
    rr = 1;
  endtask

  task automatic test_round_robin;
    int c;
    test_reset();
    eng_auto = 1'b1;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = 12; op_b[i] = 8; end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      c = 0;
      #1;
      while (req_ready == 0 && c < 20) begin @(negedge clk); #1; c++; end
      n_checks++; if (req_ready !== 4'(1 << (k % NREQ))) $display("FAIL t2_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % NREQ))); else n_pass++;
      wait_rsp();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== 4) $display("FAIL t2_gcd%0d got v=%b gcd=%0d exp v=1 gcd=4", k, rsp_valid, rsp_gcd); else n_pass++;
      n_checks++; if (rsp_id !== 2'(k % NREQ)) $display("FAIL t2_id%0d got=%0d exp=%0d", k, rsp_id, k % NREQ); else n_pass++;
      handshake();
    end
    req_valid = '0;
    rr = 1;
  endtask

  task automatic test_zero_bypass;
    logic [WIDTH-1:0] za [3] = '{0, 0, 21};
    logic [WIDTH-1:0] zb [3] = '{35, 0, 0};
    logic [WIDTH-1:0] zr [3] = '{35, 0, 21};
    int g0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_a[2] = za[i]; op_b[2] = zb[i]; req_valid = 4'b0100;
      #1;
      g0 = go_cnt;
      n_checks++; if (req_ready !== 4'b0100) $display("FAIL t3_ready%0d got=%b exp=0100", i, req_ready); else n_pass++;
      @(negedge clk);
      req_valid = '0;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== zr[i]) $display("FAIL t3_rsp%0d got v=%b gcd=%0d exp v=1 gcd=%0d", i, rsp_valid, rsp_gcd, zr[i]); else n_pass++;
      n_checks++; if (rsp_id !== 2 || eng_go !== 1'b0) $display("FAIL t3_tag%0d got id=%0d go=%b exp 2/0", i, rsp_id, eng_go); else n_pass++;
      handshake();
      #1;
      n_checks++; if (go_cnt !== g0) $display("FAIL t3_no_go%0d got=%0d exp=%0d", i, go_cnt, g0); else n_pass++;
    end
    rr = 3;
  endtask

  task automatic test_backpressure;
    eng_auto = 1'b1;
    @(negedge clk);
    op_a[1] = 100; op_b[1] = 75; req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL t4_ready got=%b exp=0010", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    wait_rsp();
    op_a[1] = 9; op_b[1] = 6; req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== 25 || rsp_id !== 1) $display("FAIL t4_hold%0d got v=%b gcd=%0d id=%0d exp 1/25/1", c, rsp_valid, rsp_gcd, rsp_id); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL t4_no_grant%0d got=%b exp=0000", c, req_ready); else n_pass++;
    end
    handshake();
    #1;
    n_checks++; if (req_ready !== 4'b0010 || busy !== 1'b0) $display("FAIL t4_regrant got=%b busy=%b exp 0010/0", req_ready, busy); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    wait_rsp();
    n_checks++; if (rsp_gcd !== 3 || rsp_id !== 1) $display("FAIL t4_second got gcd=%0d id=%0d exp 3/1", rsp_gcd, rsp_id); else n_pass++;
    handshake();
    rr = 2;
  endtask

  task automatic test_reset_mid;
    eng_auto = 1'b0;
    @(negedge clk);
    op_a[2] = 10; op_b[2] = 4; req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL t5_ready got=%b exp=0100", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL t5_wait got busy=%b v=%b exp 1/0", busy, rsp_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    n_checks++; if ({eng_go, rsp_valid, rsp_err, busy} !== 4'b0000 || req_ready !== 0) $display("FAIL t5_ctrl got=%b rdy=%b exp 0000/0000", {eng_go, rsp_valid, rsp_err, busy}, req_ready); else n_pass++;
    n_checks++; if (eng_a !== 0 || eng_b !== 0 || rsp_gcd !== 0 || rsp_id !== 0) $display("FAIL t5_data got a=%0d b=%0d gcd=%0d id=%0d exp all 0", eng_a, eng_b, rsp_gcd, rsp_id); else n_pass++;
    eng_done = 1'b1; eng_gcd = 2;
    @(negedge clk);
    eng_done = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t5_late_done got v=%b busy=%b exp 0/0", rsp_valid, busy); else n_pass++;
    eng_auto = 1'b1;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = 15; op_b[i] = 10; end
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL t5_ptr_reset got=%b exp=0001", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
    wait_rsp();
    n_checks++; if (rsp_gcd !== 5 || rsp_id !== 0) $display("FAIL t5_after got gcd=%0d id=%0d exp 5/0", rsp_gcd, rsp_id); else n_pass++;
    handshake();
    rr = 1;
  endtask

  task automatic test_watchdog;
    eng_auto = 1'b0;
    @(negedge clk);
    op_a[3] = 7; op_b[3] = 5; req_valid = 4'b1000;
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL t6_ready got=%b exp=1000", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = '0;
`ifdef GCD_ARB_TIMEOUT_EN
    wait_rsp();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) $display("FAIL t6_timeout got v=%b err=%b exp 1/1", rsp_valid, rsp_err); else n_pass++;
    n_checks++; if (rsp_gcd !== 0 || rsp_id !== 3) $display("FAIL t6_timeout_data got gcd=%0d id=%0d exp 0/3", rsp_gcd, rsp_id); else n_pass++;
    handshake();
`else
    repeat (40) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL t6_stuck got busy=%b v=%b err=%b exp 1/0/0", busy, rsp_valid, rsp_err); else n_pass++;
    eng_done = 1'b1; eng_gcd = 1;
    @(negedge clk);
    eng_done = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_gcd !== 1 || rsp_id !== 3) $display("FAIL t6_release got v=%b gcd=%0d id=%0d exp 1/1/3", rsp_valid, rsp_gcd, rsp_id); else n_pass++;
    handshake();
`endif
    rr = 0;
  endtask

  task automatic test_random;
    int               q_id [$];
    logic [WIDTH-1:0] q_gcd [$];
    logic [NREQ-1:0]  drop = '0;
    logic [NREQ-1:0]  exp_rdy;
    bit               busy_m = 1'b0;
    bit               free_next = 1'b0;
    bit               r;
    int               g, g0, n_go = 0, ei;
    logic [WIDTH-1:0] eg;
    int unsigned      k;
    eng_auto = 1'b1;
    @(negedge clk);
    #1;
    g0 = go_cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ei = (q_id.size() > 0) ? q_id[0] : -1;
        eg = (q_gcd.size() > 0) ? q_gcd[0] : '0;
        n_checks++;
        if (ei < 0 || rsp_id !== 2'(ei) || rsp_gcd !== eg || rsp_err !== 1'b0)
          $display("FAIL rnd_rsp cyc=%0d got id=%0d gcd=%0d err=%b exp id=%0d gcd=%0d err=0", cyc, rsp_id, rsp_gcd, rsp_err, ei, eg);
        else n_pass++;
      end
      r = ($urandom_range(0, 2) != 0);
      rsp_ready = r;
      if (rsp_valid === 1'b1 && r && q_id.size() > 0) begin
        void'(q_id.pop_front());
        void'(q_gcd.pop_front());
        free_next = 1'b1;
      end
      req_valid = req_valid & ~drop;
      drop = '0;
      if (cyc < 300) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, 500);
            op_a[i] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'(k * $urandom_range(1, 60));
            op_b[i] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'(k * $urandom_range(1, 60));
            req_valid[i] = 1'b1;
          end
        end
      end
      #1;
      exp_rdy = '0;
      g = -1;
      if (!busy_m && req_valid != 0) begin
        g = exp_grant(req_valid);
        exp_rdy = 4'(1 << g);
      end
      n_checks++;
      if (req_ready !== exp_rdy) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      else n_pass++;
      if (g >= 0) begin
        q_id.push_back(g);
        q_gcd.push_back(ref_gcd(op_a[g], op_b[g]));
        if (op_a[g] != 0 && op_b[g] != 0) n_go++;
        rr = (g + 1) % NREQ;
        busy_m = 1'b1;
        drop = exp_rdy;
      end
      if (free_next) begin
        busy_m = 1'b0;
        free_next = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (q_id.size() != 0) $display("FAIL rnd_drain got=%0d outstanding exp=0", q_id.size()); else n_pass++;
    n_checks++; if (go_cnt - g0 !== n_go) $display("FAIL rnd_go_count got=%0d exp=%0d", go_cnt - g0, n_go); else n_pass++;
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    eng_done  = 1'b0;
    eng_gcd   = '0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_zero_bypass();
    test_backpressure();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
